// File: rtl/axis_route_ctrl.sv
// axis_route_ctrl
// Front-end controller for a 4-port AXI-Stream demux.
// - Input beats pass through a single output register, one cycle of latency,
//   and can stream at one beat per cycle.
// - The route (sel) and the drop decision are taken from the first beat of
//   each frame. They stay fixed until the last beat of that frame has been
//   accepted downstream.
// - Optional per-route statistics are built only when AXIS_ROUTE_STATS_EN is
//   defined. When it is not defined, the statistics ports are tied to zero.
module axis_route_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [DEST_WIDTH-1:0] s_axis_tdest,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic [USER_WIDTH-1:0] m_axis_tuser,

    input  logic                  route_enable,
    input  logic                  route_drop,

    output logic                  enable,
    output logic                  drop,
    output logic [1:0]            sel,

    output logic [31:0]           stat_frames0,
    output logic [31:0]           stat_frames1,
    output logic [31:0]           stat_frames2,
    output logic [31:0]           stat_frames3,
    output logic [31:0]           stat_drops
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    state_t                state_reg;
    state_t                state_next;

    logic [DATA_WIDTH-1:0] tdata_reg;
    logic [KEEP_WIDTH-1:0] tkeep_reg;
    logic [DEST_WIDTH-1:0] tdest_reg;
    logic [USER_WIDTH-1:0] tuser_reg;
    logic                  tvalid_reg;
    logic                  tlast_reg;

    logic [1:0]            sel_reg;
    logic                  drop_reg;
    logic                  enable_reg;

    logic                  in_ready;
    logic                  in_accept;
    logic                  out_accept;
    logic                  first_beat;
    logic                  dest_high_set;

    // A tdest whose bits above the two port-select bits are non-zero names a
    // port that does not exist, so such a frame is dropped.
    generate
        if (DEST_WIDTH > 2) begin : g_dest_hi
            assign dest_high_set = |s_axis_tdest[DEST_WIDTH-1:2];
        end else begin : g_dest_lo
            assign dest_high_set = 1'b0;
        end
    endgenerate

    // Input handshake.
    // - The output slot must be free or draining in this same cycle.
    // - A new frame may start only while route_enable is high.
    // - A frame already in progress always completes.
    // - Nothing is accepted while reset is asserted.
    assign in_ready   = !rst
                      && (m_axis_tready || !tvalid_reg)
                      && ((state_reg == ST_FRAME) || route_enable);
    assign in_accept  = s_axis_tvalid && in_ready;
    assign out_accept = tvalid_reg && m_axis_tready;
    assign first_beat = in_accept && (state_reg == ST_IDLE);

    // Frame-tracking state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    // - A single-beat frame (tlast on the first beat) keeps the FSM in IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_accept && !s_axis_tlast) begin
                    state_next = ST_FRAME;
                end
            end
            ST_FRAME: begin
                if (in_accept && s_axis_tlast) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output-slot control.
    // - Load the slot on every accepted input beat.
    // - Otherwise empty it once the downstream side takes the beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            tvalid_reg <= 1'b0;
            tlast_reg  <= 1'b0;
        end else if (in_accept) begin
            tvalid_reg <= 1'b1;
            tlast_reg  <= s_axis_tlast;
        end else if (m_axis_tready) begin
            tvalid_reg <= 1'b0;
        end
    end

    // Output-slot payload.
    // - Passed through unchanged.
    // - Not reset, because tvalid qualifies it.
    always_ff @(posedge clk) begin
        if (in_accept) begin
            tdata_reg <= s_axis_tdata;
            tkeep_reg <= s_axis_tkeep;
            tdest_reg <= s_axis_tdest;
            tuser_reg <= s_axis_tuser;
        end
    end

    // Routing decision.
    // - Captured on the first beat of a frame only.
    // - The register changes on the same edge that loads that beat into the
    //   output slot, so sel and drop always describe the beat on m_axis_*.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_reg  <= 2'b00;
            drop_reg <= 1'b0;
        end else if (first_beat) begin
            sel_reg  <= s_axis_tdest[1:0];
            drop_reg <= route_drop | dest_high_set;
        end
    end

    // Demux enable.
    // - Follows route_enable only while no frame is open and the output slot
    //   is empty.
    // - It therefore never changes under a beat that is still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            enable_reg <= 1'b0;
        end else if ((state_reg == ST_IDLE) && !tvalid_reg) begin
            enable_reg <= route_enable;
        end
    end

    assign s_axis_tready = in_ready;

    assign m_axis_tdata  = tdata_reg;
    assign m_axis_tkeep  = tkeep_reg;
    assign m_axis_tdest  = tdest_reg;
    assign m_axis_tuser  = tuser_reg;
    assign m_axis_tvalid = tvalid_reg;
    assign m_axis_tlast  = tlast_reg;

    assign sel    = sel_reg;
    assign drop   = drop_reg;
    assign enable = enable_reg;

`ifdef AXIS_ROUTE_STATS_EN
    logic [31:0] frame_count [4];
    logic [31:0] drops_reg;
    logic        frame_done;

    // A frame is counted when its tlast beat leaves the output slot.
    assign frame_done = out_accept && tlast_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_frame_cnt
            logic [31:0] cnt_reg;

            // Frames delivered on route gi. The counter wraps naturally.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= 32'd0;
                end else if (frame_done && !drop_reg && (sel_reg == 2'(gi))) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end

            assign frame_count[gi] = cnt_reg;
        end
    endgenerate

    // Frames discarded by the demux. The counter wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            drops_reg <= 32'd0;
        end else if (frame_done && drop_reg) begin
            drops_reg <= drops_reg + 32'd1;
        end
    end

    assign stat_frames0 = frame_count[0];
    assign stat_frames1 = frame_count[1];
    assign stat_frames2 = frame_count[2];
    assign stat_frames3 = frame_count[3];
    assign stat_drops   = drops_reg;
`else
    // The statistics ports stay in place so that both builds share one
    // footprint.
    assign stat_frames0 = 32'd0;
    assign stat_frames1 = 32'd0;
    assign stat_frames2 = 32'd0;
    assign stat_frames3 = 32'd0;
    assign stat_drops   = 32'd0;
`endif

endmodule

// File: tb/tb_axis_route_ctrl.sv
// tb_axis_route_ctrl
// Directed bench for axis_route_ctrl.
// - A queue scoreboard receives each beat when the DUT accepts it.
// - The beat is checked every cycle while it sits in the output slot.
// - It is retired when the downstream side accepts it.
// - A small frame model predicts sel, drop, enable and (when
//   AXIS_ROUTE_STATS_EN is defined) the statistics counters.
module tb_axis_route_ctrl;

`ifdef AXIS_ROUTE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [7:0]  s_axis_tdest;
    logic [0:0]  s_axis_tuser;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [7:0]  m_axis_tdest;
    logic [0:0]  m_axis_tuser;
    logic        route_enable;
    logic        route_drop;
    logic        enable;
    logic        drop;
    logic [1:0]  sel;
    logic [31:0] stat_frames0, stat_frames1, stat_frames2, stat_frames3, stat_drops;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [7:0]  dest;
        logic [0:0]  user;
    } beat_t;

    beat_t       sb[$];
    logic        rdy_pat[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic        in_frame = 1'b0;
    logic [1:0]  exp_sel = 2'd0;
    logic        exp_drop = 1'b0;
    logic        exp_enable = 1'b0;
    int unsigned exp_frames [4] = '{0, 0, 0, 0};
    int unsigned exp_drops = 0;
    logic        last_in_acc = 1'b0;
    logic [31:0] snap_drops, snap_f1;

    axis_route_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tdest  (s_axis_tdest),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdest  (m_axis_tdest),
        .m_axis_tuser  (m_axis_tuser),
        .route_enable  (route_enable),
        .route_drop    (route_drop),
        .enable        (enable),
        .drop          (drop),
        .sel           (sel),
        .stat_frames0  (stat_frames0),
        .stat_frames1  (stat_frames1),
        .stat_frames2  (stat_frames2),
        .stat_frames3  (stat_frames3),
        .stat_drops    (stat_drops)
    );

    always #5 clk = ~clk;

    // Safety net so that the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock.
    // - Apply the next downstream ready value.
    // - Check the DUT at the falling edge.
    // - Update the scoreboard and model from the handshakes seen there.
    task automatic cycle();
        logic  in_acc, out_acc, pend;
        beat_t b;
        if (rdy_pat.size() != 0) m_axis_tready = rdy_pat.pop_front();
        else                     m_axis_tready = 1'b1;
        @(negedge clk);
        if (rst) begin
            chk("rst_tready", 64'(s_axis_tready), 64'd0);
            @(posedge clk);
            #1;
            sb.delete();
            in_frame    = 1'b0;
            exp_enable  = 1'b0;
            exp_sel     = 2'd0;
            exp_drop    = 1'b0;
            exp_drops   = 0;
            for (int i = 0; i < 4; i++) exp_frames[i] = 0;
            last_in_acc = 1'b0;
            return;
        end
        pend    = (sb.size() != 0);
        in_acc  = s_axis_tvalid && s_axis_tready;
        out_acc = m_axis_tvalid && m_axis_tready;
        chk("s_tready", 64'(s_axis_tready),
            64'((m_axis_tready || !pend) && (in_frame || route_enable)));
        chk("m_tvalid", 64'(m_axis_tvalid), 64'(pend));
        chk("sel", 64'(sel), 64'(exp_sel));
        chk("drop", 64'(drop), 64'(exp_drop));
        chk("enable", 64'(enable), 64'(exp_enable));
        chk("stat_frames0", 64'(stat_frames0), STATS ? 64'(exp_frames[0]) : 64'd0);
        chk("stat_frames1", 64'(stat_frames1), STATS ? 64'(exp_frames[1]) : 64'd0);
        chk("stat_frames2", 64'(stat_frames2), STATS ? 64'(exp_frames[2]) : 64'd0);
        chk("stat_frames3", 64'(stat_frames3), STATS ? 64'(exp_frames[3]) : 64'd0);
        chk("stat_drops", 64'(stat_drops), STATS ? 64'(exp_drops) : 64'd0);
        if (pend) begin
            b = sb[0];
            chk("m_tdata", 64'(m_axis_tdata), 64'(b.data));
            chk("m_tkeep", 64'(m_axis_tkeep), 64'(b.keep));
            chk("m_tlast", 64'(m_axis_tlast), 64'(b.last));
            chk("m_tdest", 64'(m_axis_tdest), 64'(b.dest));
            chk("m_tuser", 64'(m_axis_tuser), 64'(b.user));
        end
        if (out_acc && pend) begin
            b = sb.pop_front();
            $display("beat out data=%h last=%b dest=%h sel=%0d drop=%b",
                     b.data, b.last, b.dest, exp_sel, exp_drop);
            if (b.last) begin
                if (exp_drop) exp_drops++;
                else          exp_frames[exp_sel]++;
            end
        end
        if (!in_frame && !pend) exp_enable = route_enable;
        if (in_acc) begin
            if (!in_frame) begin
                exp_sel  = s_axis_tdest[1:0];
                exp_drop = route_drop || (s_axis_tdest[7:2] != '0);
            end
            b.data = s_axis_tdata;
            b.keep = s_axis_tkeep;
            b.last = s_axis_tlast;
            b.dest = s_axis_tdest;
            b.user = s_axis_tuser;
            sb.push_back(b);
            in_frame = !s_axis_tlast;
        end
        last_in_acc = in_acc;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic l, input logic [7:0] dst);
        s_axis_tdata  = d;
        s_axis_tkeep  = d[7:4];
        s_axis_tlast  = l;
        s_axis_tdest  = dst;
        s_axis_tuser  = d[0];
        s_axis_tvalid = 1'b1;
    endtask

    // Offer one beat until it is accepted (bounded).
    // - exp_cyc != 0 also checks how many cycles the acceptance took.
    task automatic send(input logic [31:0] d, input logic l, input logic [7:0] dst,
                        input int exp_cyc);
        int n;
        n = 0;
        drive(d, l, dst);
        do begin
            cycle();
            n++;
        end while (!last_in_acc && n < 40);
        chk("send_accepted", 64'(last_in_acc), 64'd1);
        if (exp_cyc != 0) chk("accept_cycles", 64'(n), 64'(exp_cyc));
        s_axis_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
        s_axis_tdest = '0; s_axis_tuser = '0;
        m_axis_tready = 1'b1;
        route_enable = 1'b0;
        route_drop = 1'b0;

        // Reset state.
        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_sel", 64'(sel), 64'd0);
        chk("rst_drop", 64'(drop), 64'd0);
        chk("rst_enable", 64'(enable), 64'd0);
        route_enable = 1'b1;
        cycle();
        chk("enable_follow", 64'(enable), 64'd1);

        // Single-beat frame to route 2.
        send(32'h1111_00A1, 1'b1, 8'h02, 1);
        chk("single_tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("single_tlast", 64'(m_axis_tlast), 64'd1);
        chk("single_sel", 64'(sel), 64'd2);
        chk("single_drop", 64'(drop), 64'd0);
        idle(2);

        // Four-beat frame. tdest changes mid-frame, but the route must not
        // follow it. The beats run back to back.
        send(32'h2222_0010, 1'b0, 8'h01, 1);
        send(32'h2222_0021, 1'b0, 8'h03, 1);
        chk("mid_sel_b2", 64'(sel), 64'd1);
        send(32'h2222_0030, 1'b0, 8'h01, 1);
        send(32'h2222_0041, 1'b1, 8'h01, 1);
        chk("mid_sel_b4", 64'(sel), 64'd1);
        route_enable = 1'b0;
        #1;
        chk("back_to_idle", 64'(s_axis_tready), 64'd0);
        idle(2);

        // route_enable low while idle blocks the input. Dropping route_enable
        // mid-frame must not stop the frame.
        drive(32'h3333_0050, 1'b0, 8'h00);
        cycle();
        cycle();
        chk("blocked_tready", 64'(s_axis_tready), 64'd0);
        route_enable = 1'b1;
        send(32'h3333_0050, 1'b0, 8'h00, 1);
        route_enable = 1'b0;
        send(32'h3333_0061, 1'b0, 8'h00, 1);
        send(32'h3333_0070, 1'b1, 8'h00, 1);
        route_enable = 1'b1;
        idle(3);

        // An out-of-range tdest drops the frame but keeps sel from the low bits.
        snap_drops = stat_drops;
        snap_f1    = stat_frames1;
        send(32'h4444_0081, 1'b0, 8'h05, 1);
        chk("oor_drop", 64'(drop), 64'd1);
        chk("oor_sel", 64'(sel), 64'd1);
        send(32'h4444_0090, 1'b1, 8'h05, 1);
        idle(2);
        chk("oor_drops_delta", 64'(stat_drops - snap_drops), STATS ? 64'd1 : 64'd0);
        chk("oor_f1_delta", 64'(stat_frames1 - snap_f1), 64'd0);

        // route_drop is sampled on the first beat only.
        route_drop = 1'b1;
        send(32'h5555_00A0, 1'b0, 8'h00, 1);
        route_drop = 1'b0;
        send(32'h5555_00B1, 1'b1, 8'h00, 1);
        chk("forced_drop", 64'(drop), 64'd1);
        idle(2);

        // Downstream stall during a three-beat frame (ready 1,0,0,1).
        rdy_pat.push_back(1'b1);
        rdy_pat.push_back(1'b0);
        rdy_pat.push_back(1'b0);
        rdy_pat.push_back(1'b1);
        send(32'h6666_00C0, 1'b0, 8'h03, 1);
        send(32'h6666_00D1, 1'b0, 8'h03, 3);
        send(32'h6666_00E0, 1'b1, 8'h03, 1);
        idle(2);

        // Reset after beat 2 of a four-beat frame.
        send(32'h7777_00F1, 1'b0, 8'h02, 1);
        send(32'h7777_0100, 1'b0, 8'h02, 1);
        rst = 1'b1;
        drive(32'h7777_0111, 1'b0, 8'h02);
        cycle();
        rst = 1'b0;
        chk("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("midrst_sel", 64'(sel), 64'd0);
        send(32'h8888_0121, 1'b1, 8'h03, 1);
        chk("post_rst_sel", 64'(sel), 64'd3);
        chk("post_rst_data", 64'(m_axis_tdata), 64'h8888_0121);
        idle(2);

        // Mixed traffic with random stalls and destinations.
        for (int k = 0; k < 24; k++) begin
            rdy_pat.push_back(1'($urandom_range(0, 1)));
            send($urandom, (k == 23) ? 1'b1 : 1'($urandom_range(0, 3) == 0),
                 8'($urandom_range(0, 7)), 0);
        end
        idle(4);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_route_ctrl.md
AXIS_ROUTE_CTRL -- requirements
Module: axis_route_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: tdata width in bits.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8: tkeep width.
REQ-003 SHALL have parameter DEST_WIDTH, default 8: tdest width; minimum 2.
REQ-004 SHALL have parameter USER_WIDTH, default 1: tuser width.
REQ-005 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have ports s_axis_tdata/tkeep/tvalid/tready/tlast/tdest/tuser, with directions in/in/in/out/in/in/in and widths DATA/KEEP/1/1/1/DEST/USER: input stream.
REQ-008 SHALL have ports m_axis_tdata/tkeep/tvalid/tready/tlast/tdest/tuser, with directions out/out/out/in/out/out/out and the same widths: registered output stream feeding the 4-port demux.
REQ-009 SHALL have port route_enable, input, 1: permits a new frame to start.
REQ-010 SHALL have port route_drop, input, 1: forces drop of the next frame started.
REQ-011 SHALL have ports enable, drop and sel, output, widths 1/1/2: demux control.
REQ-012 SHALL have ports stat_frames0..stat_frames3 and stat_drops, output, 32 each: statistics.

Function
REQ-013 SHALL implement a one-stage output register: an accepted input beat appears on m_axis_* exactly 1 cycle later.
REQ-014 SHALL drive s_axis_tready = (m_axis_tready OR NOT m_axis_tvalid) AND (state==FRAME OR route_enable).
REQ-015 SHALL load the output register on every input accept; otherwise clear m_axis_tvalid when m_axis_tready is high.
REQ-016 SHALL implement a 2-state FSM: IDLE (awaiting first beat) and FRAME (mid-frame).
REQ-017 IDLE->FRAME on accept of a beat with tlast=0; an accepted tlast=1 beat in IDLE (single-beat frame) leaves the FSM in IDLE.
REQ-018 FRAME->IDLE on accept of a beat with tlast=1; in FRAME, route_enable SHALL be ignored.
REQ-019 On accept of a first beat, SHALL register sel = s_axis_tdest[1:0].
REQ-020 On accept of a first beat, SHALL register drop = route_drop OR (s_axis_tdest[DEST_WIDTH-1:2] != 0).
REQ-021 sel and drop SHALL hold constant until the output beat carrying tlast is accepted downstream.
REQ-022 enable SHALL be a registered copy of route_enable, updated only when the FSM is IDLE and no output beat is pending.
REQ-023 tdata, tkeep, tdest and tuser SHALL pass unmodified.
REQ-024 With simultaneous input accept and output accept of the same cycle's beat, SHALL sustain 1 beat/cycle with no bubble.
REQ-025 With m_axis_tready low and m_axis_tvalid high, SHALL hold all m_axis_* stable (no data loss, no duplication).

Reset
REQ-026 rst high at a clock edge SHALL force: FSM=IDLE; m_axis_tvalid=0, m_axis_tlast=0; sel=0, drop=0, enable=0; statistics=0.
REQ-027 m_axis_tdata, tkeep, tdest and tuser need not be reset.
REQ-028 Reset mid-frame SHALL discard the partial frame; the first accept after reset is treated as a first beat.
REQ-029 s_axis_tready SHALL be 0 during any cycle with rst high.

Configuration
REQ-030 Macro AXIS_ROUTE_STATS_EN defined SHALL compile in statistics, counted on downstream accept of a tlast beat:
- stat_frames[sel] increments when drop=0.
- stat_drops increments when drop=1.
- All counters 32-bit, wrap from 0xFFFFFFFF to 0.
REQ-031 Macro AXIS_ROUTE_STATS_EN undefined SHALL leave the statistics ports present and tied to 0, with no counter logic.

Verification
REQ-032 Single-beat frame, tdest=0x02, route_enable=1, m_axis_tready=1 -> next cycle m_axis_tvalid=1, tlast=1, sel=2, drop=0.
REQ-033 4-beat frame, tdest=0x01, with tdest changed to 0x03 on beat 2 -> sel stays 1 for all 4 output beats; FSM back to IDLE after beat 4.
REQ-034 tdest=0x05 -> drop=1, sel=1; with STATS_EN, stat_drops=1 and stat_frames1=0 after tlast.
REQ-035 m_axis_tready toggling 1,0,0,1 during a 3-beat frame -> output data order preserved, no beat lost or duplicated, s_axis_tready low while stalled.
REQ-036 route_enable=0 in IDLE -> s_axis_tready=0; route_enable=0 asserted mid-frame -> frame completes.
REQ-037 rst asserted after beat 2 of a 4-beat frame -> m_axis_tvalid=0 and sel=0 next cycle; the next beat accepted is routed by its own tdest.
